sync_up_counter: RTL and testbench

- Fully synchronous modulo-N up counter; the count-up counterpart of the team's ripple down counter.
- All state bits change on the same `clk` edge, so there are no ripple glitches on `q`.
- Provides parallel load, count enable, terminal-count/carry-out for cascading, and a sticky wrap flag.
- Used as a timebase and event counter; also serves as the reference model that the down-counter benches check against.

---
 rtl/sync_up_counter.sv | 151 +++++++++++++++
 tb/tb_sync_up_counter.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/sync_up_counter.sv
// Synchronous modulo-MODULO up counter with parallel load, count enable,
// cascade carry-out, a sticky wrap flag and a load-error pulse.
// All state bits update on the same clk edge, so q is glitch-free.
// The property checker below is attached to every instance through bind.

module sync_up_counter_chk #(
    parameter int WIDTH  = 4,
    parameter int MODULO = 16
) (
    input logic             clk,
    input logic             rst,
    input logic             en,
    input logic             load,
    input logic [WIDTH-1:0] q,
    input logic [WIDTH-1:0] q_bar,
    input logic             co,
    input logic             wrap
);

    localparam logic [WIDTH-1:0] TC_VAL = WIDTH'(MODULO - 1);

    // A plain counting cycle advances q by exactly one
    a_count_inc: assert property (@(posedge clk) disable iff (!rst)
        (en && !load && (q != TC_VAL)) |=> (q == ($past(q) + 1'b1)));

    // An enabled cycle at the terminal value rolls q back to zero
    a_count_roll: assert property (@(posedge clk) disable iff (!rst)
        (en && !load && (q == TC_VAL)) |=> (q == {WIDTH{1'b0}}));

    // The rollover always leaves the sticky wrap flag set
    a_wrap_set: assert property (@(posedge clk) disable iff (!rst)
        (en && !load && (q == TC_VAL)) |=> wrap);

    // q_bar is always the bitwise complement of q
    a_qbar: assert property (@(posedge clk) disable iff (!rst)
        (q_bar == ~q));

    // Carry-out can only be produced by an enabled stage
    a_co_en: assert property (@(posedge clk) disable iff (!rst)
        (!en |-> !co));

endmodule

module sync_up_counter #(
    parameter int WIDTH  = 4,
    parameter int MODULO = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             clr_wrap,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] q_bar,
    output logic             tc,
    output logic             co,
    output logic             wrap,
    output logic             load_err
);

    // Reject a count range that is empty or does not fit in WIDTH bits
    if ((MODULO < 2) || (64'(MODULO) > (64'd1 << WIDTH))) begin : g_bad_modulo
        $error("sync_up_counter: MODULO must satisfy 2 <= MODULO <= 2**WIDTH");
    end

    localparam logic [WIDTH-1:0] TC_VAL  = WIDTH'(MODULO - 1);
    // One extra bit so MODULO == 2**WIDTH is representable for the load check
    localparam logic [WIDTH:0]   MOD_VAL = (WIDTH + 1)'(MODULO);

    logic [WIDTH-1:0] q_r;
    logic             wrap_r;
    logic             load_err_r;
    logic [WIDTH-1:0] q_nxt_s;
    logic             wrap_nxt_s;
    logic             load_err_nxt_s;
    logic             tc_s;
    logic             load_ok_s;
    logic             roll_s;

    assign tc_s      = (q_r == TC_VAL);
    assign load_ok_s = ({1'b0, load_val} < MOD_VAL);
    // A rollover happens only on an enabled, non-load edge at the terminal value
    assign roll_s    = tc_s & en & ~load;

    // Next-state selection: load beats enable; wrap set beats wrap clear
    always_comb begin
        q_nxt_s        = q_r;
        wrap_nxt_s     = wrap_r;
        load_err_nxt_s = 1'b0;
        if (load) begin
            if (load_ok_s) begin
                q_nxt_s = load_val;
            end else begin
                q_nxt_s        = {WIDTH{1'b0}};
                load_err_nxt_s = 1'b1;
            end
        end else if (en) begin
            if (tc_s) begin
                q_nxt_s = {WIDTH{1'b0}};
            end else begin
                // Out-of-range states also increment and wrap at 2**WIDTH
                q_nxt_s = q_r + {{(WIDTH - 1){1'b0}}, 1'b1};
            end
        end else begin
            q_nxt_s = q_r;
        end
        if (roll_s) begin
            wrap_nxt_s = 1'b1;
        end else if (clr_wrap) begin
            wrap_nxt_s = 1'b0;
        end else begin
            wrap_nxt_s = wrap_r;
        end
    end

    // State registers with immediate clear when rst falls
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q_r        <= {WIDTH{1'b0}};
            wrap_r     <= 1'b0;
            load_err_r <= 1'b0;
        end else begin
            q_r        <= q_nxt_s;
            wrap_r     <= wrap_nxt_s;
            load_err_r <= load_err_nxt_s;
        end
    end

    assign q        = q_r;
    assign q_bar    = ~q_r;
    assign tc       = tc_s;
    assign co       = roll_s;
    assign wrap     = wrap_r;
    assign load_err = load_err_r;

endmodule

bind sync_up_counter sync_up_counter_chk #(
    .WIDTH  (WIDTH),
    .MODULO (MODULO)
) u_chk (
    .clk   (clk),
    .rst   (rst),
    .en    (en),
    .load  (load),
    .q     (q),
    .q_bar (q_bar),
    .co    (co),
    .wrap  (wrap)
);

// File: tb/tb_sync_up_counter.sv
// Self-checking bench for sync_up_counter: a MODULO=16 and a MODULO=10
// instance share one stimulus stream, and two MODULO=16 stages are cascaded
// into an 8-bit counter. Expected values come from an arithmetic model.

module tb_sync_up_counter;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       load;
    logic [3:0] load_val;
    logic       clr_wrap;

    logic [3:0] q_s     [2];
    logic [3:0] q_bar_s [2];
    logic       tc_s    [2];
    logic       co_s    [2];
    logic       wrap_s  [2];
    logic       lerr_s  [2];

    logic       c_rst;
    logic       c_en;
    logic [3:0] lo_q_s, lo_qb_s, hi_q_s, hi_qb_s;
    logic       lo_tc_s, lo_co_s, lo_wrap_s, lo_lerr_s;
    logic       hi_tc_s, hi_co_s, hi_wrap_s, hi_lerr_s;

    int n_tests = 0;
    int n_fail  = 0;

    int mod    [2] = '{16, 10};
    int m_q    [2];
    int m_wrap [2];
    int m_lerr [2];
    int c_cnt;
    int c_lo_wrap;
    int c_hi_wrap;

    // Free-running 10-unit clock
    always #5 clk = ~clk;

    sync_up_counter #(.WIDTH(4), .MODULO(16)) u_dut16 (
        .clk(clk), .rst(rst), .en(en), .load(load), .load_val(load_val),
        .clr_wrap(clr_wrap), .q(q_s[0]), .q_bar(q_bar_s[0]), .tc(tc_s[0]),
        .co(co_s[0]), .wrap(wrap_s[0]), .load_err(lerr_s[0]));

    sync_up_counter #(.WIDTH(4), .MODULO(10)) u_dut10 (
        .clk(clk), .rst(rst), .en(en), .load(load), .load_val(load_val),
        .clr_wrap(clr_wrap), .q(q_s[1]), .q_bar(q_bar_s[1]), .tc(tc_s[1]),
        .co(co_s[1]), .wrap(wrap_s[1]), .load_err(lerr_s[1]));

    sync_up_counter #(.WIDTH(4), .MODULO(16)) u_lo (
        .clk(clk), .rst(c_rst), .en(c_en), .load(1'b0), .load_val(4'd0),
        .clr_wrap(1'b0), .q(lo_q_s), .q_bar(lo_qb_s), .tc(lo_tc_s),
        .co(lo_co_s), .wrap(lo_wrap_s), .load_err(lo_lerr_s));

    sync_up_counter #(.WIDTH(4), .MODULO(16)) u_hi (
        .clk(clk), .rst(c_rst), .en(lo_co_s), .load(1'b0), .load_val(4'd0),
        .clr_wrap(1'b0), .q(hi_q_s), .q_bar(hi_qb_s), .tc(hi_tc_s),
        .co(hi_co_s), .wrap(hi_wrap_s), .load_err(hi_lerr_s));

    task automatic chk_eq(input string tag, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_q[k] = 0; m_wrap[k] = 0; m_lerr[k] = 0;
        end
    endtask

    // Advance every model by one clock edge using the inputs present at it
    task automatic model_update();
        for (int k = 0; k < 2; k++) begin
            if (!rst) begin
                m_q[k] = 0; m_wrap[k] = 0; m_lerr[k] = 0;
            end else if (load) begin
                m_lerr[k] = (int'(load_val) >= mod[k]) ? 1 : 0;
                m_q[k]    = (m_lerr[k] != 0) ? 0 : int'(load_val);
                if (clr_wrap) m_wrap[k] = 0;
            end else begin
                m_lerr[k] = 0;
                if (en && (m_q[k] == mod[k] - 1)) begin
                    m_q[k] = 0; m_wrap[k] = 1;
                end else begin
                    if (en) m_q[k] = (m_q[k] + 1) % 16;
                    if (clr_wrap) m_wrap[k] = 0;
                end
            end
        end
        if (!c_rst) begin
            c_cnt = 0; c_lo_wrap = 0; c_hi_wrap = 0;
        end else if (c_en) begin
            if (c_cnt % 16 == 15) c_lo_wrap = 1;
            if (c_cnt == 255)     c_hi_wrap = 1;
            c_cnt = (c_cnt + 1) % 256;
        end
    endtask

    task automatic check_all();
        int tcx;
        for (int k = 0; k < 2; k++) begin
            tcx = (m_q[k] == mod[k] - 1) ? 1 : 0;
            chk_eq($sformatf("q_m%0d", mod[k]),     int'(q_s[k]), m_q[k]);
            chk_eq($sformatf("q_bar_m%0d", mod[k]), int'(q_bar_s[k]), 15 - m_q[k]);
            chk_eq($sformatf("tc_m%0d", mod[k]),    int'(tc_s[k]), tcx);
            chk_eq($sformatf("co_m%0d", mod[k]),    int'(co_s[k]),
                   (tcx != 0 && en && !load) ? 1 : 0);
            chk_eq($sformatf("wrap_m%0d", mod[k]),  int'(wrap_s[k]), m_wrap[k]);
            chk_eq($sformatf("lerr_m%0d", mod[k]),  int'(lerr_s[k]), m_lerr[k]);
        end
        chk_eq("casc_q",     int'({hi_q_s, lo_q_s}), c_cnt);
        chk_eq("casc_qbar",  int'({hi_qb_s, lo_qb_s}), 255 - c_cnt);
        chk_eq("casc_lo_tc", int'(lo_tc_s), (c_cnt % 16 == 15) ? 1 : 0);
        chk_eq("casc_hi_tc", int'(hi_tc_s), (c_cnt >= 240) ? 1 : 0);
        chk_eq("casc_hi_co", int'(hi_co_s), (c_cnt == 255 && c_en) ? 1 : 0);
        chk_eq("casc_wraps", int'({lo_wrap_s, hi_wrap_s}), c_lo_wrap * 2 + c_hi_wrap);
        chk_eq("casc_lerr",  int'({lo_lerr_s, hi_lerr_s}), 0);
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        #1;
        check_all();
    endtask

    // Drop rst mid-period and confirm the clear is immediate
    task automatic async_reset();
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        check_all();
    endtask

    initial begin
        rst = 1'b0; en = 1'b0; load = 1'b0; load_val = 4'd0; clr_wrap = 1'b0;
        c_rst = 1'b0; c_en = 1'b0;
        model_reset();
        c_cnt = 0; c_lo_wrap = 0; c_hi_wrap = 0;
        #3;
        check_all();
        step();
        step();
        rst = 1'b1;

        // Free count through one rollover
        en = 1'b1;
        for (int i = 0; i < 20; i++) step();

        // Load takes priority over enable; out-of-range load on MODULO=10
        load = 1'b1; load_val = 4'd13;
        step();
        load = 1'b0;
        for (int i = 0; i < 3; i++) step();

        // Illegal load value then a full MODULO=10 cycle
        load = 1'b1; load_val = 4'd12;
        step();
        load = 1'b0;
        for (int i = 0; i < 12; i++) step();

        // Asynchronous reset at q=7; inputs ignored while low; hold after release
        load = 1'b1; load_val = 4'd7;
        step();
        load = 1'b0; en = 1'b0;
        async_reset();
        en = 1'b1; load = 1'b1; load_val = 4'd5;
        step();
        rst = 1'b1; en = 1'b0; load = 1'b0;
        for (int i = 0; i < 3; i++) step();

        // Clear coinciding with rollover loses; clear alone works
        load = 1'b1; load_val = 4'd14;
        step();
        load = 1'b0; en = 1'b1;
        step();
        clr_wrap = 1'b1;
        step();
        en = 1'b0;
        step();
        clr_wrap = 1'b0;
        step();

        // Randomized traffic with occasional asynchronous resets
        for (int i = 0; i < 200; i++) begin
            en       = ($urandom_range(0, 3) != 0);
            load     = ($urandom_range(0, 7) == 0);
            load_val = 4'($urandom_range(0, 15));
            clr_wrap = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 29) == 0) begin
                async_reset();
                step();
                rst = 1'b1;
            end else begin
                step();
            end
        end
        en = 1'b0; load = 1'b0; clr_wrap = 1'b0;

        // Cascaded 8-bit counter through a full 255->0 wrap
        c_rst = 1'b1; c_en = 1'b1;
        for (int i = 0; i < 300; i++) step();
        for (int i = 0; i < 30; i++) begin
            c_en = ($urandom_range(0, 1) != 0);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
